// File: rtl/ctrl_ramdrv_ringwr_pkg.sv
// Shared controller package for the ring-buffer drivers.
// Provides the ring FSM state encoding and the offset-to-address
// zero-extension macro that both the write and read drivers use.
// Optional feature macro seen by the drivers: CTRL_RINGWR_PRIME_EN.

`ifndef CTRL_OFF2ADDR
// Zero-extend a ring offset to the RAM address width before address adds.
`define CTRL_OFF2ADDR(off, aw) ((aw)'(off))
`endif

package ctrl_ramdrv_ringwr_pkg;

  typedef logic [1:0] ringwr_state_t;

  localparam ringwr_state_t UNCFG = 2'd0;
  localparam ringwr_state_t RUN   = 2'd1;
  localparam ringwr_state_t HOLD  = 2'd2;

endpackage

// File: rtl/ctrl_ramdrv_ringwr_if.sv
// Sample-in stream and RAM write port of the ring write driver.
// slave: the driver side; master: the producer / RAM model side.

interface ctrl_ramdrv_ringwr_if #(
  parameter int DATA_ADDRESS_WIDTH = 12,
  parameter int SAMPLE_WIDTH       = 16
);

  logic                          s_valid;
  logic                          s_ready;
  logic [SAMPLE_WIDTH-1:0]       s_data;
  logic                          ram_we;
  logic [DATA_ADDRESS_WIDTH-1:0] ram_addr;
  logic [SAMPLE_WIDTH-1:0]       ram_wdata;

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready,
    output ram_we,
    output ram_addr,
    output ram_wdata
  );

  modport master (
    output s_valid,
    output s_data,
    input  s_ready,
    input  ram_we,
    input  ram_addr,
    input  ram_wdata
  );

endinterface

// File: rtl/ctrl_ramdrv_ringwr_hold.sv
// Single-entry hold register with a valid flag. Parks one sample while a
// read pass locks the ring. flush beats load, load beats release.

module ctrl_ringwr_hold #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load_i,
  input  logic         rls_i,
  input  logic         flush_i,
  input  logic [W-1:0] din_i,
  output logic         valid_o,
  output logic [W-1:0] dout_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // Next value of the hold entry from the flush/load/release controls.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
      data_d  = '0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = din_i;
    end else if (rls_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Hold entry storage; a reset discards any parked sample.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign dout_o  = data_q;

endmodule

// File: rtl/ctrl_ramdrv_ringwr.sv
// Write-side driver for the per-channel sample ring in data RAM.
// Writes each accepted sample to the next ring slot between data_uptr and
// data_lptr, publishes the newest slot as head_offset, and parks one
// sample while rd_lock is high so the head never moves during a read pass.
// Optional feature: CTRL_RINGWR_PRIME_EN builds the fill counter.

module ctrl_ramdrv_ringwr
  import ctrl_ramdrv_ringwr_pkg::*;
#(
  parameter int DATA_ADDRESS_WIDTH = 12,
  parameter int DATA_OFFSET_WIDTH  = 10,
  parameter int SAMPLE_WIDTH       = 16
) (
  input  logic                         clk,
  input  logic                         clr,
  input  logic                         init,
  input  logic [DATA_ADDRESS_WIDTH-1:0] data_uptr,
  input  logic [DATA_ADDRESS_WIDTH-1:0] data_lptr,
  input  logic                         rd_lock,
  ctrl_ramdrv_ringwr_if.slave          bus,
  output logic [DATA_OFFSET_WIDTH-1:0] head_offset,
  output logic                         new_sample,
  output logic                         cfg_err,
  output logic                         primed,
  output logic [DATA_OFFSET_WIDTH:0]   fill_count
);

  localparam int AW = DATA_ADDRESS_WIDTH;
  localparam int OW = DATA_OFFSET_WIDTH;
  localparam int SW = SAMPLE_WIDTH;

  ringwr_state_t state_q, state_d;
  logic [AW-1:0] uptr_q, uptr_d;
  logic [AW-1:0] lptr_q, lptr_d;
  logic [OW-1:0] head_q, head_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [SW-1:0] wdata_q, wdata_d;
  logic          new_q, new_d;
  logic          err_q, err_d;

  logic [AW-1:0] diff_s;
  logic          legal_s;
  logic          wrap_s;
  logic [OW-1:0] nxt_s;
  logic          commit_s;
  logic [SW-1:0] cdata_s;
  logic          hold_load_s, hold_rls_s, hold_flush_s;
  logic          hold_valid_s;
  logic [SW-1:0] hold_data_s;

  // Bounds legality: lptr must not be below uptr and the ring must fit the offset range.
  assign diff_s  = data_lptr - data_uptr;
  assign legal_s = (data_lptr >= data_uptr) &&
                   (64'(diff_s) < (64'd1 << OW));

  // Next slot wraps on address compare against the upper bound.
  assign wrap_s = ((uptr_q + `CTRL_OFF2ADDR(head_q, AW)) == lptr_q);
  assign nxt_s  = wrap_s ? {OW{1'b0}} : (head_q + OW'(1));

  // Ready depends only on state and init so there is no combinational path from s_valid.
  assign bus.s_ready = (state_q == RUN) && !init;

  ctrl_ringwr_hold #(.W(SW)) u_hold (
    .clk     (clk),
    .clr     (clr),
    .load_i  (hold_load_s),
    .rls_i   (hold_rls_s),
    .flush_i (hold_flush_s),
    .din_i   (bus.s_data),
    .valid_o (hold_valid_s),
    .dout_o  (hold_data_s)
  );

  // Next-state logic; init wins over any stream or lock activity.
  always_comb begin
    state_d = state_q;
    if (init) begin
      state_d = legal_s ? RUN : UNCFG;
    end else begin
      case (state_q)
        UNCFG: state_d = UNCFG;
        RUN: begin
          if (bus.s_valid && rd_lock) begin
            state_d = HOLD;
          end else begin
            state_d = RUN;
          end
        end
        HOLD: begin
          if (!rd_lock) begin
            state_d = RUN;
          end else begin
            state_d = HOLD;
          end
        end
        default: state_d = UNCFG;
      endcase
    end
  end

  // Commit decision, hold controls and next values of the registered outputs.
  always_comb begin
    commit_s     = 1'b0;
    cdata_s      = bus.s_data;
    hold_load_s  = 1'b0;
    hold_rls_s   = 1'b0;
    hold_flush_s = 1'b0;
    if (init) begin
      hold_flush_s = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (bus.s_valid) begin
            if (rd_lock) begin
              hold_load_s = 1'b1;
            end else begin
              commit_s = 1'b1;
            end
          end else begin
            commit_s = 1'b0;
          end
        end
        HOLD: begin
          if (!rd_lock) begin
            commit_s   = hold_valid_s;
            cdata_s    = hold_data_s;
            hold_rls_s = 1'b1;
          end else begin
            commit_s = 1'b0;
          end
        end
        default: commit_s = 1'b0;
      endcase
    end

    uptr_d = init ? data_uptr : uptr_q;
    lptr_d = init ? data_lptr : lptr_q;

    if (init && legal_s) begin
      head_d = OW'(diff_s);
    end else if (commit_s) begin
      head_d = nxt_s;
    end else begin
      head_d = head_q;
    end

    we_d    = commit_s;
    new_d   = commit_s;
    addr_d  = commit_s ? (uptr_q + `CTRL_OFF2ADDR(nxt_s, AW)) : {AW{1'b0}};
    wdata_d = commit_s ? cdata_s : {SW{1'b0}};
    err_d   = init && !legal_s;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= UNCFG;
    end else begin
      state_q <= state_d;
    end
  end

  // Ring bounds, head and RAM write port registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      uptr_q  <= '0;
      lptr_q  <= '0;
      head_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      new_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      uptr_q  <= uptr_d;
      lptr_q  <= lptr_d;
      head_q  <= head_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      new_q   <= new_d;
      err_q   <= err_d;
    end
  end

`ifdef CTRL_RINGWR_PRIME_EN
  logic [OW:0] len_q, len_d;
  logic [OW:0] fill_q, fill_d;
  logic        primed_q, primed_d;

  // Fill counter saturates at the ring length; primed latches when it gets there.
  always_comb begin
    len_d    = len_q;
    fill_d   = fill_q;
    primed_d = primed_q;
    if (init) begin
      len_d    = legal_s ? ((OW + 1)'(diff_s) + (OW + 1)'(1)) : len_q;
      fill_d   = '0;
      primed_d = 1'b0;
    end else if (commit_s) begin
      if (fill_q < len_q) begin
        fill_d = fill_q + (OW + 1)'(1);
      end else begin
        fill_d = fill_q;
      end
      primed_d = primed_q || (fill_d == len_q);
    end else begin
      fill_d = fill_q;
    end
  end

  // Fill counter registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      len_q    <= '0;
      fill_q   <= '0;
      primed_q <= 1'b0;
    end else begin
      len_q    <= len_d;
      fill_q   <= fill_d;
      primed_q <= primed_d;
    end
  end

  assign fill_count = fill_q;
  assign primed     = primed_q;
`else
  logic primed_q;

  // Without the fill counter, primed simply tracks a configured ring.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      primed_q <= 1'b0;
    end else begin
      primed_q <= (state_d != UNCFG);
    end
  end

  assign fill_count = '0;
  assign primed     = primed_q;
`endif

  assign bus.ram_we    = we_q;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_wdata = wdata_q;
  assign head_offset   = head_q;
  assign new_sample    = new_q;
  assign cfg_err       = err_q;

endmodule

// File: tb/tb_ctrl_ramdrv_ringwr.sv
// Directed bench for ctrl_ramdrv_ringwr: reset, wrap, lock stall, init
// collision, bounds legality (including a 4-bit offset instance) and a
// single-slot ring. Expected values are hand-computed.

module tb_ctrl_ramdrv_ringwr;

`ifdef CTRL_RINGWR_PRIME_EN
  localparam bit PRIME = 1'b1;
`else
  localparam bit PRIME = 1'b0;
`endif

  logic        clk;
  logic        clr;
  logic        init;
  logic [11:0] uptr;
  logic [11:0] lptr;
  logic        rd_lock;
  logic [9:0]  head;
  logic        new_sample;
  logic        cfg_err;
  logic        primed;
  logic [10:0] fill;
  logic [3:0]  head4;
  logic        new4;
  logic        err4;
  logic        primed4;
  logic [4:0]  fill4;

  int checks;
  int errors;

  ctrl_ramdrv_ringwr_if #(.DATA_ADDRESS_WIDTH(12), .SAMPLE_WIDTH(16)) bus ();
  ctrl_ramdrv_ringwr_if #(.DATA_ADDRESS_WIDTH(12), .SAMPLE_WIDTH(16)) bus4 ();

  ctrl_ramdrv_ringwr #(
    .DATA_ADDRESS_WIDTH(12), .DATA_OFFSET_WIDTH(10), .SAMPLE_WIDTH(16)
  ) dut (
    .clk(clk), .clr(clr), .init(init), .data_uptr(uptr), .data_lptr(lptr),
    .rd_lock(rd_lock), .bus(bus), .head_offset(head), .new_sample(new_sample),
    .cfg_err(cfg_err), .primed(primed), .fill_count(fill)
  );

  ctrl_ramdrv_ringwr #(
    .DATA_ADDRESS_WIDTH(12), .DATA_OFFSET_WIDTH(4), .SAMPLE_WIDTH(16)
  ) dut4 (
    .clk(clk), .clr(clr), .init(init), .data_uptr(uptr), .data_lptr(lptr),
    .rd_lock(rd_lock), .bus(bus4), .head_offset(head4), .new_sample(new4),
    .cfg_err(err4), .primed(primed4), .fill_count(fill4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [11:0] wrap_addr [5] = '{12'h100, 12'h101, 12'h102, 12'h103, 12'h100};
  logic [9:0]  wrap_head [5] = '{10'd0, 10'd1, 10'd2, 10'd3, 10'd0};

  initial begin
    checks = 0;
    errors = 0;
    clr = 1'b1; init = 1'b0; uptr = 12'h000; lptr = 12'h000; rd_lock = 1'b0;
    bus.s_valid = 1'b0; bus.s_data = 16'h0000;
    bus4.s_valid = 1'b0; bus4.s_data = 16'h0000;
    tick();
    tick();

    // Reset values
    chk("rst_ready", {31'd0, bus.s_ready}, 32'd0);
    chk("rst_we", {31'd0, bus.ram_we}, 32'd0);
    chk("rst_addr_wdata", {4'd0, bus.ram_addr, bus.ram_wdata}, 32'd0);
    chk("rst_head", {22'd0, head}, 32'd0);
    chk("rst_flags", {28'd0, new_sample, cfg_err, primed, 1'b0}, 32'd0);
    chk("rst_fill", {21'd0, fill}, 32'd0);

    // Unconfigured: no ready, no write
    clr = 1'b0;
    bus.s_valid = 1'b1; bus.s_data = 16'hBEEF;
    #1;
    chk("uncfg_ready", {31'd0, bus.s_ready}, 32'd0);
    tick();
    chk("uncfg_we", {31'd0, bus.ram_we}, 32'd0);

    // Legal init 0x100..0x103
    init = 1'b1; uptr = 12'h100; lptr = 12'h103; bus.s_data = 16'hDEAD;
    #1;
    chk("init_ready", {31'd0, bus.s_ready}, 32'd0);
    tick();
    init = 1'b0; bus.s_valid = 1'b0;
    chk("init_head", {22'd0, head}, 32'd3);
    chk("init_err", {31'd0, cfg_err}, 32'd0);
    chk("init_we", {31'd0, bus.ram_we}, 32'd0);
    chk("init_fill", {21'd0, fill}, 32'd0);
    chk("init_primed", {31'd0, primed}, PRIME ? 32'd0 : 32'd1);
    #1;
    chk("run_ready", {31'd0, bus.s_ready}, 32'd1);

    // Stream A..E back to back, wrapping at lptr
    for (int i = 0; i < 5; i++) begin
      bus.s_valid = 1'b1; bus.s_data = 16'h0A00 + 16'(i);
      tick();
      chk("wrap_we", {31'd0, bus.ram_we}, 32'd1);
      chk("wrap_addr", {20'd0, bus.ram_addr}, {20'd0, wrap_addr[i]});
      chk("wrap_wdata", {16'd0, bus.ram_wdata}, 32'h0A00 + 32'(i));
      chk("wrap_head", {22'd0, head}, {22'd0, wrap_head[i]});
      chk("wrap_new", {31'd0, new_sample}, 32'd1);
      chk("wrap_fill", {21'd0, fill}, PRIME ? ((i < 4) ? 32'(i + 1) : 32'd4) : 32'd0);
      chk("wrap_primed", {31'd0, primed}, PRIME ? ((i >= 3) ? 32'd1 : 32'd0) : 32'd1);
    end
    bus.s_valid = 1'b0;
    tick();
    chk("idle_we", {31'd0, bus.ram_we}, 32'd0);
    chk("idle_new", {31'd0, new_sample}, 32'd0);

    // Lock stall: 0x1234 parked, then committed after release
    rd_lock = 1'b1; bus.s_valid = 1'b1; bus.s_data = 16'h1234;
    #1;
    chk("lock_ready_pre", {31'd0, bus.s_ready}, 32'd1);
    tick();
    bus.s_data = 16'h9999;
    #1;
    chk("hold_ready", {31'd0, bus.s_ready}, 32'd0);
    chk("hold_we", {31'd0, bus.ram_we}, 32'd0);
    tick();
    chk("hold_we2", {31'd0, bus.ram_we}, 32'd0);
    chk("hold_head", {22'd0, head}, 32'd0);
    bus.s_valid = 1'b0; rd_lock = 1'b0;
    #1;
    chk("release_we_early", {31'd0, bus.ram_we}, 32'd0);
    tick();
    chk("release_we", {31'd0, bus.ram_we}, 32'd1);
    chk("release_addr", {20'd0, bus.ram_addr}, 32'h101);
    chk("release_wdata", {16'd0, bus.ram_wdata}, 32'h1234);
    chk("release_head", {22'd0, head}, 32'd1);
    chk("release_fill", {21'd0, fill}, PRIME ? 32'd4 : 32'd0);
    tick();
    chk("release_we_off", {31'd0, bus.ram_we}, 32'd0);
    chk("release_ready", {31'd0, bus.s_ready}, 32'd1);

    // Init collision while holding a sample
    rd_lock = 1'b1; bus.s_valid = 1'b1; bus.s_data = 16'h5555;
    tick();
    init = 1'b1; rd_lock = 1'b0; bus.s_data = 16'h6666;
    #1;
    chk("coll_ready", {31'd0, bus.s_ready}, 32'd0);
    tick();
    init = 1'b0; bus.s_valid = 1'b0;
    chk("coll_we", {31'd0, bus.ram_we}, 32'd0);
    chk("coll_head", {22'd0, head}, 32'd3);
    chk("coll_fill", {21'd0, fill}, 32'd0);
    chk("coll_primed", {31'd0, primed}, PRIME ? 32'd0 : 32'd1);
    tick();
    chk("coll_no_held_write", {31'd0, bus.ram_we}, 32'd0);
    chk("coll_head2", {22'd0, head}, 32'd3);

    // Illegal bounds: lptr below uptr (init also collides with s_valid in RUN)
    init = 1'b1; uptr = 12'h200; lptr = 12'h1FF; bus.s_valid = 1'b1; bus.s_data = 16'h7777;
    #1;
    chk("ill_ready_run", {31'd0, bus.s_ready}, 32'd0);
    tick();
    init = 1'b0; bus.s_valid = 1'b0;
    chk("ill_err", {31'd0, cfg_err}, 32'd1);
    chk("ill_err4", {31'd0, err4}, 32'd1);
    chk("ill_we", {31'd0, bus.ram_we}, 32'd0);
    chk("ill_primed", {31'd0, primed}, 32'd0);
    chk("ill_ready", {31'd0, bus.s_ready}, 32'd0);
    tick();
    chk("ill_err_pulse", {31'd0, cfg_err}, 32'd0);

    // Ring length 17: legal at 10 bits, too long for the 4-bit instance
    init = 1'b1; uptr = 12'h000; lptr = 12'h010;
    tick();
    init = 1'b0;
    chk("len17_err", {31'd0, cfg_err}, 32'd0);
    chk("len17_head", {22'd0, head}, 32'h010);
    chk("len17_err4", {31'd0, err4}, 32'd1);

    // Ring length 16: legal for both
    init = 1'b1; lptr = 12'h00F;
    tick();
    init = 1'b0;
    chk("len16_err4", {31'd0, err4}, 32'd0);
    chk("len16_head4", {28'd0, head4}, 32'hF);
    chk("len16_head", {22'd0, head}, 32'h00F);

    // Ring length 1024 legal, 1025 illegal at 10 bits
    init = 1'b1; lptr = 12'h3FF;
    tick();
    init = 1'b0;
    chk("len1024_err", {31'd0, cfg_err}, 32'd0);
    chk("len1024_head", {22'd0, head}, 32'h3FF);
    init = 1'b1; lptr = 12'h400;
    tick();
    init = 1'b0;
    chk("len1025_err", {31'd0, cfg_err}, 32'd1);

    // Single-slot ring at 0x050
    init = 1'b1; uptr = 12'h050; lptr = 12'h050;
    tick();
    init = 1'b0;
    chk("single_head_init", {22'd0, head}, 32'd0);
    chk("single_err", {31'd0, cfg_err}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      bus.s_valid = 1'b1; bus.s_data = 16'h0C00 + 16'(i);
      tick();
      chk("single_we", {31'd0, bus.ram_we}, 32'd1);
      chk("single_addr", {20'd0, bus.ram_addr}, 32'h050);
      chk("single_wdata", {16'd0, bus.ram_wdata}, 32'h0C00 + 32'(i));
      chk("single_head", {22'd0, head}, 32'd0);
      chk("single_fill", {21'd0, fill}, PRIME ? 32'd1 : 32'd0);
      chk("single_primed", {31'd0, primed}, 32'd1);
    end
    bus.s_valid = 1'b0;

    // Asynchronous clear mid-cycle after two writes
    init = 1'b1; uptr = 12'h100; lptr = 12'h103;
    tick();
    init = 1'b0; bus.s_valid = 1'b1; bus.s_data = 16'h0D00;
    tick();
    bus.s_data = 16'h0D01;
    tick();
    bus.s_valid = 1'b0;
    chk("pre_clr_head", {22'd0, head}, 32'd1);
    chk("pre_clr_we", {31'd0, bus.ram_we}, 32'd1);
    #3;
    clr = 1'b1;
    #1;
    chk("clr_we", {31'd0, bus.ram_we}, 32'd0);
    chk("clr_head", {22'd0, head}, 32'd0);
    chk("clr_addr_wdata", {4'd0, bus.ram_addr, bus.ram_wdata}, 32'd0);
    chk("clr_flags", {29'd0, new_sample, cfg_err, primed}, 32'd0);
    chk("clr_fill", {21'd0, fill}, 32'd0);
    chk("clr_ready", {31'd0, bus.s_ready}, 32'd0);
    chk("clr_dut4", {fill4, primed4, bus4.s_ready, new4, err4, head4, 19'd0}, 32'd0);
    chk("dut4_idle", {2'd0, bus4.ram_addr, bus4.ram_wdata, bus4.ram_we, 1'b0}, 32'd0);
    @(posedge clk);
    #1;
    clr = 1'b0; bus.s_valid = 1'b1; bus.s_data = 16'h0E00;
    #1;
    chk("post_clr_ready", {31'd0, bus.s_ready}, 32'd0);
    tick();
    chk("post_clr_we", {31'd0, bus.ram_we}, 32'd0);
    bus.s_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
